// File: rtl/fb_write_arbiter.sv
// -----------------------------------------------------------------------------
// fb_write_arbiter
//   Shares the single framebuffer write port between NUM_REQ pixel sources
//   (index 0 = sprite painter, then HUD overlay, screen-clear engine).
//   Round-robin burst arbitration: once granted, a source owns the port until
//   it presents a beat marked last, or until MAX_GRANT_CYCLES grant cycles
//   have elapsed (forced release, flagged by timeout_pulse).
//   An arbitration cycle in IDLE never transfers a beat, so consecutive bursts
//   are separated by a one-cycle bubble. Accepted beats reach the write port
//   exactly one cycle later. Single clock domain (33 MHz).
//
// Ports
//   clk_33m        in   clock
//   rst            in   asynchronous active-high reset
//   req_valid      in   per-requester beat valid
//   req_x/y        in   per-requester pixel coordinates (packed, index 0 at LSB)
//   req_palette    in   per-requester palette index (packed)
//   req_last       in   per-requester last-beat marker
//   req_ready      out  one-hot ready to the current owner while granted
//   write_en       out  framebuffer write strobe (registered)
//   write_x/y      out  framebuffer write coordinates (hold between writes)
//   write_palette  out  framebuffer write palette (holds between writes)
//   owner          out  current / most recent grant owner
//   busy           out  high while a grant is active
//   timeout_pulse  out  one-cycle pulse after a forced release
// -----------------------------------------------------------------------------
module fb_write_arbiter #(
  parameter int NUM_REQ          = 3,
  parameter int X_W              = 12,
  parameter int Y_W              = 12,
  parameter int PAL_W            = 3,
  parameter int MAX_GRANT_CYCLES = 4096,
  localparam int OWN_W           = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1,
  localparam int CNT_W           = $clog2(MAX_GRANT_CYCLES)
) (
  input  logic                     clk_33m,
  input  logic                     rst,
  input  logic [NUM_REQ-1:0]       req_valid,
  input  logic [NUM_REQ*X_W-1:0]   req_x,
  input  logic [NUM_REQ*Y_W-1:0]   req_y,
  input  logic [NUM_REQ*PAL_W-1:0] req_palette,
  input  logic [NUM_REQ-1:0]       req_last,
  output logic [NUM_REQ-1:0]       req_ready,
  output logic                     write_en,
  output logic [X_W-1:0]           write_x,
  output logic [Y_W-1:0]           write_y,
  output logic [PAL_W-1:0]         write_palette,
  output logic [OWN_W-1:0]         owner,
  output logic                     busy,
  output logic                     timeout_pulse
);

  typedef enum logic [0:0] {
    ST_IDLE  = 1'b0,
    ST_GRANT = 1'b1
  } state_t;

  state_t             state_r, state_nxt_s;
  logic [OWN_W-1:0]   owner_r, owner_nxt_s;
  logic [OWN_W-1:0]   last_owner_r, last_owner_nxt_s;
  logic [OWN_W-1:0]   pick_s, cand_s;
  logic               pick_found_s;
  logic [CNT_W-1:0]   cnt_r, cnt_nxt_s;
  logic               accept_s, at_limit_s, timeout_nxt_s;
  logic [NUM_REQ-1:0] ready_s;
  logic               write_en_r, timeout_r;
  logic [X_W-1:0]     write_x_r;
  logic [Y_W-1:0]     write_y_r;
  logic [PAL_W-1:0]   write_pal_r;

  // Round-robin pick: first valid requester searching from last_owner+1 upward, wrapping.
  always_comb begin
    pick_s       = last_owner_r;
    pick_found_s = 1'b0;
    cand_s       = last_owner_r;
    for (int k = 1; k <= NUM_REQ; k++) begin
      cand_s = OWN_W'((int'(last_owner_r) + k) % NUM_REQ);
      if (!pick_found_s && req_valid[cand_s]) begin
        pick_s       = cand_s;
        pick_found_s = 1'b1;
      end else begin
        pick_found_s = pick_found_s;
      end
    end
  end

  // Grant decode: ready depends only on state and owner, never on valid.
  always_comb begin
    ready_s = {NUM_REQ{1'b0}};
    if (state_r == ST_GRANT) begin
      ready_s[owner_r] = 1'b1;
    end else begin
      ready_s = {NUM_REQ{1'b0}};
    end
  end

  // cnt_r holds the number of grant cycles already completed, so the
  // current grant cycle is cnt_r+1 and the limit is reached at MAX-1.
  assign accept_s   = (state_r == ST_GRANT) && req_valid[owner_r];
  assign at_limit_s = (cnt_r == CNT_W'(MAX_GRANT_CYCLES - 1));

  // Next-state logic: arbitration in IDLE, release on last beat or grant timeout.
  always_comb begin
    state_nxt_s      = state_r;
    owner_nxt_s      = owner_r;
    last_owner_nxt_s = last_owner_r;
    cnt_nxt_s        = cnt_r;
    timeout_nxt_s    = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (pick_found_s) begin
          state_nxt_s = ST_GRANT;
          owner_nxt_s = pick_s;
          cnt_nxt_s   = {CNT_W{1'b0}};
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_GRANT: begin
        cnt_nxt_s = cnt_r + CNT_W'(1);
        // A last beat on the limit cycle is a normal release: no timeout flag.
        if (accept_s && req_last[owner_r]) begin
          state_nxt_s      = ST_IDLE;
          last_owner_nxt_s = owner_r;
        end else if (at_limit_s) begin
          state_nxt_s      = ST_IDLE;
          last_owner_nxt_s = owner_r;
          timeout_nxt_s    = 1'b1;
        end else begin
          state_nxt_s = ST_GRANT;
        end
      end
      default: begin
        state_nxt_s = ST_IDLE;
      end
    endcase
  end

  // Arbitration state registers.
  always_ff @(posedge clk_33m or posedge rst) begin
    if (rst) begin
      state_r      <= ST_IDLE;
      owner_r      <= {OWN_W{1'b0}};
      last_owner_r <= OWN_W'(NUM_REQ - 1);
      cnt_r        <= {CNT_W{1'b0}};
      timeout_r    <= 1'b0;
    end else begin
      state_r      <= state_nxt_s;
      owner_r      <= owner_nxt_s;
      last_owner_r <= last_owner_nxt_s;
      cnt_r        <= cnt_nxt_s;
      timeout_r    <= timeout_nxt_s;
    end
  end

  // Write port: capture the accepted beat; coordinates hold when nothing is written.
  always_ff @(posedge clk_33m or posedge rst) begin
    if (rst) begin
      write_en_r  <= 1'b0;
      write_x_r   <= {X_W{1'b0}};
      write_y_r   <= {Y_W{1'b0}};
      write_pal_r <= {PAL_W{1'b0}};
    end else begin
      write_en_r <= accept_s;
      if (accept_s) begin
        write_x_r   <= req_x[owner_r*X_W +: X_W];
        write_y_r   <= req_y[owner_r*Y_W +: Y_W];
        write_pal_r <= req_palette[owner_r*PAL_W +: PAL_W];
      end else begin
        write_x_r   <= write_x_r;
        write_y_r   <= write_y_r;
        write_pal_r <= write_pal_r;
      end
    end
  end

  assign req_ready     = ready_s;
  assign write_en      = write_en_r;
  assign write_x       = write_x_r;
  assign write_y       = write_y_r;
  assign write_palette = write_pal_r;
  assign owner         = owner_r;
  assign busy          = (state_r == ST_GRANT);
  assign timeout_pulse = timeout_r;

endmodule

// File: tb/tb_fb_write_arbiter.sv
// -----------------------------------------------------------------------------
// tb_fb_write_arbiter
//   Self-checking bench for fb_write_arbiter (NUM_REQ=3, MAX_GRANT_CYCLES=8).
//   Inputs change on the falling edge, outputs are checked on the falling edge.
//   A grant-level reference model (plain integers, round-robin by modular
//   search) predicts every output each cycle; directed sequences add their own
//   hand-derived expectations on top.
// -----------------------------------------------------------------------------
module tb_fb_write_arbiter;

  localparam int N    = 3;
  localparam int XW   = 12;
  localparam int YW   = 12;
  localparam int PW   = 3;
  localparam int MAXG = 8;
  localparam int OW   = 2;

  logic            clk_33m = 1'b0;
  logic            rst;
  logic [N-1:0]    req_valid, req_last, req_ready;
  logic [N*XW-1:0] req_x;
  logic [N*YW-1:0] req_y;
  logic [N*PW-1:0] req_palette;
  logic            write_en, busy, timeout_pulse;
  logic [XW-1:0]   write_x;
  logic [YW-1:0]   write_y;
  logic [PW-1:0]   write_palette;
  logic [OW-1:0]   owner;

  int n_cmp = 0;
  int n_bad = 0;

  always #15 clk_33m = ~clk_33m;

  fb_write_arbiter #(
    .NUM_REQ(N), .X_W(XW), .Y_W(YW), .PAL_W(PW), .MAX_GRANT_CYCLES(MAXG)
  ) dut (
    .clk_33m(clk_33m), .rst(rst),
    .req_valid(req_valid), .req_x(req_x), .req_y(req_y),
    .req_palette(req_palette), .req_last(req_last), .req_ready(req_ready),
    .write_en(write_en), .write_x(write_x), .write_y(write_y),
    .write_palette(write_palette), .owner(owner), .busy(busy),
    .timeout_pulse(timeout_pulse)
  );

  // ---------------- reference model ----------------
  bit            m_granted;
  logic [OW-1:0] m_owner, m_last;
  int            m_age;
  logic          m_we, m_to;
  logic [XW-1:0] m_x;
  logic [YW-1:0] m_y;
  logic [PW-1:0] m_p;

  function automatic logic [OW-1:0] rr_pick(input logic [OW-1:0] last, input logic [N-1:0] v);
    for (int k = 1; k <= N; k++) begin
      int idx;
      idx = (int'(last) + k) % N;
      if (v[idx[OW-1:0]]) return idx[OW-1:0];
    end
    return last;
  endfunction

  // Grant-level behaviour of the arbiter, one step per clock.
  always @(posedge clk_33m or posedge rst) begin
    if (rst) begin
      m_granted <= 1'b0; m_owner <= 2'd0; m_last <= 2'(N - 1); m_age <= 0;
      m_we <= 1'b0; m_to <= 1'b0; m_x <= '0; m_y <= '0; m_p <= '0;
    end else if (!m_granted) begin
      m_we <= 1'b0;
      m_to <= 1'b0;
      if (req_valid != 3'b000) begin
        m_owner   <= rr_pick(m_last, req_valid);
        m_granted <= 1'b1;
        m_age     <= 0;
      end
    end else begin
      m_age <= m_age + 1;
      m_to  <= 1'b0;
      m_we  <= req_valid[m_owner];
      if (req_valid[m_owner]) begin
        m_x <= req_x[m_owner*XW +: XW];
        m_y <= req_y[m_owner*YW +: YW];
        m_p <= req_palette[m_owner*PW +: PW];
      end
      if (req_valid[m_owner] && req_last[m_owner]) begin
        m_granted <= 1'b0; m_last <= m_owner;
      end else if (m_age + 1 == MAXG) begin
        m_granted <= 1'b0; m_last <= m_owner; m_to <= 1'b1;
      end
    end
  end

  // ---------------- helpers ----------------
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic check_model(input string tag);
    logic [N-1:0] exp_rdy;
    exp_rdy = m_granted ? (3'b001 << m_owner) : 3'b000;
    check({tag, ".we"},    32'(write_en),      32'(m_we));
    check({tag, ".x"},     32'(write_x),       32'(m_x));
    check({tag, ".y"},     32'(write_y),       32'(m_y));
    check({tag, ".pal"},   32'(write_palette), 32'(m_p));
    check({tag, ".owner"}, 32'(owner),         32'(m_owner));
    check({tag, ".busy"},  32'(busy),          32'(m_granted));
    check({tag, ".to"},    32'(timeout_pulse), 32'(m_to));
    check({tag, ".rdy"},   32'(req_ready),     32'(exp_rdy));
  endtask

  task automatic check_zero(input string tag);
    check({tag, ".we"},    32'(write_en),      32'd0);
    check({tag, ".rdy"},   32'(req_ready),     32'd0);
    check({tag, ".busy"},  32'(busy),          32'd0);
    check({tag, ".owner"}, 32'(owner),         32'd0);
    check({tag, ".to"},    32'(timeout_pulse), 32'd0);
  endtask

  task automatic set_req(input int i, input logic v, input logic l,
                         input logic [XW-1:0] x, input logic [YW-1:0] y, input logic [PW-1:0] p);
    req_valid[i]          = v;
    req_last[i]           = l;
    req_x[i*XW +: XW]     = x;
    req_y[i*YW +: YW]     = y;
    req_palette[i*PW +: PW] = p;
  endtask

  task automatic do_reset();
    @(negedge clk_33m);
    rst = 1'b1; req_valid = 3'b000; req_last = 3'b000;
    @(negedge clk_33m);
    rst = 1'b0;
  endtask

  // ---------------- directed table (single-source burst) ----------------
  typedef struct {
    logic          v;
    logic          l;
    logic [XW-1:0] x;
    logic          e_we;
    logic [XW-1:0] e_x;
    logic          e_busy;
    logic [N-1:0]  e_rdy;
  } vec_t;

  vec_t tbl[5];

  initial begin
    int wr_q[$];
    int grants[$];
    int exp_order[6];
    int n_wr, n_to, beat;
    logic prev_we, prev_busy;

    tbl[0] = '{1'b1, 1'b0, 12'd5, 1'b0, 12'd0, 1'b1, 3'b010};
    tbl[1] = '{1'b1, 1'b0, 12'd5, 1'b1, 12'd5, 1'b1, 3'b010};
    tbl[2] = '{1'b1, 1'b0, 12'd6, 1'b1, 12'd6, 1'b1, 3'b010};
    tbl[3] = '{1'b1, 1'b1, 12'd7, 1'b1, 12'd7, 1'b0, 3'b000};
    tbl[4] = '{1'b0, 1'b0, 12'd7, 1'b0, 12'd7, 1'b0, 3'b000};

    rst = 1'b1; req_valid = '0; req_last = '0; req_x = '0; req_y = '0; req_palette = '0;

    // 1: reset held while inputs toggle randomly
    for (int c = 0; c < 6; c++) begin
      @(negedge clk_33m);
      check_zero("rst_hold");
      req_valid = 3'($urandom); req_last = 3'($urandom);
      req_x = 36'({$urandom, $urandom}); req_y = 36'({$urandom, $urandom});
      req_palette = 9'($urandom);
    end
    do_reset();
    req_x = '0; req_y = '0; req_palette = '0;

    // 2: req1 alone, three beats
    for (int i = 0; i < 5; i++) begin
      set_req(1, tbl[i].v, tbl[i].l, tbl[i].x, 12'd2, 3'd3);
      @(negedge clk_33m);
      check($sformatf("tbl%0d.we", i),    32'(write_en),  32'(tbl[i].e_we));
      check($sformatf("tbl%0d.x", i),     32'(write_x),   32'(tbl[i].e_x));
      check($sformatf("tbl%0d.busy", i),  32'(busy),      32'(tbl[i].e_busy));
      check($sformatf("tbl%0d.rdy", i),   32'(req_ready), 32'(tbl[i].e_rdy));
      check($sformatf("tbl%0d.owner", i), 32'(owner),     32'd1);
      if (tbl[i].e_we) begin
        check($sformatf("tbl%0d.y", i),   32'(write_y),       32'd2);
        check($sformatf("tbl%0d.pal", i), 32'(write_palette), 32'd3);
      end
      check_model("t2");
    end

    // 3: all three valid, single-beat bursts -> order 0,1,2,0,1,2
    do_reset();
    for (int i = 0; i < N; i++) set_req(i, 1'b1, 1'b1, 12'(100 + i), 12'(i), 3'(i));
    prev_we = 1'b0;
    for (int c = 0; c < 12; c++) begin
      @(negedge clk_33m);
      check_model("t3");
      if (write_en) begin
        wr_q.push_back(int'(write_x));
        check("t3.no_back_to_back", 32'(prev_we), 32'd0);
      end
      prev_we = write_en;
    end
    check("t3.nwrites", 32'(wr_q.size()), 32'd6);
    exp_order = '{100, 101, 102, 100, 101, 102};
    for (int i = 0; i < 6 && i < wr_q.size(); i++)
      check($sformatf("t3.order%0d", i), 32'(wr_q[i]), 32'(exp_order[i]));

    // 4: owner stalls mid-burst while others wait
    do_reset();
    for (int i = 0; i < N; i++) set_req(i, 1'b1, 1'b0, 12'(10 + i), 12'd4, 3'd1);
    @(negedge clk_33m); check_model("t4.grant");
    check("t4.grant_owner", 32'(owner), 32'd0);
    @(negedge clk_33m); check_model("t4.beat1");
    check("t4.beat1_x", 32'(write_x), 32'd10);
    req_valid[0] = 1'b0;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk_33m);
      check_model("t4.stall");
      check("t4.stall_we", 32'(write_en), 32'd0);
      check("t4.stall_busy", 32'(busy), 32'd1);
      check("t4.stall_rdy", 32'(req_ready), 32'b001);
    end
    set_req(0, 1'b1, 1'b1, 12'd11, 12'd4, 3'd1);
    @(negedge clk_33m); check_model("t4.last");
    check("t4.last_x", 32'(write_x), 32'd11);
    check("t4.last_busy", 32'(busy), 32'd0);
    req_valid = 3'b000;

    // 5: req2 streams without last -> forced release after MAXG cycles
    do_reset();
    set_req(2, 1'b1, 1'b0, 12'd200, 12'd7, 3'd5);
    n_wr = 0; n_to = 0; prev_busy = 1'b0; grants.delete();
    for (int c = 0; c < 16; c++) begin
      @(negedge clk_33m);
      check_model("t5");
      if (c == 0) begin
        set_req(0, 1'b1, 1'b1, 12'd20, 12'd1, 3'd1);
        set_req(1, 1'b1, 1'b1, 12'd21, 12'd1, 3'd2);
      end
      if (busy && !prev_busy) grants.push_back(int'(owner));
      if (write_en && owner == 2'd2 && n_to == 0) n_wr++;
      if (timeout_pulse) n_to++;
      prev_busy = busy;
      req_x[2*XW +: XW] = 12'(200 + c);
    end
    check("t5.writes_before_to", 32'(n_wr), 32'd8);
    check("t5.timeouts", 32'(n_to), 32'd1);
    check("t5.ngrants", 32'(grants.size()), 32'd4);
    if (grants.size() == 4) begin
      check("t5.g0", 32'(grants[0]), 32'd2);
      check("t5.g1", 32'(grants[1]), 32'd0);
      check("t5.g2", 32'(grants[2]), 32'd1);
      check("t5.g3", 32'(grants[3]), 32'd2);
    end
    req_valid = 3'b000; req_last = 3'b000;

    // 6: asynchronous reset in the middle of a long burst
    do_reset();
    beat = 0; n_wr = 0;
    set_req(0, 1'b1, 1'b0, 12'd300, 12'd9, 3'd6);
    for (int c = 0; c < 20 && n_wr < 4; c++) begin
      @(negedge clk_33m);
      check_model("t6");
      if (write_en) begin n_wr++; beat++; end
      set_req(0, 1'b1, (beat == 9), 12'(300 + beat), 12'd9, 3'd6);
    end
    check("t6.reached_4", 32'(n_wr), 32'd4);
    @(posedge clk_33m);
    #3 rst = 1'b1;
    #1 check_zero("t6.async");
    check("t6.async.x", 32'(write_x), 32'd0);
    @(negedge clk_33m);
    rst = 1'b0;
    for (int i = 0; i < N; i++) set_req(i, 1'b1, 1'b1, 12'(400 + i), 12'd0, 3'd0);
    @(negedge clk_33m); check_model("t6.rearb");
    check("t6.first_owner", 32'(owner), 32'd0);
    check("t6.no_stale_write", 32'(write_en), 32'd0);
    @(negedge clk_33m); check_model("t6.first_write");
    check("t6.first_x", 32'(write_x), 32'd400);

    // Random traffic against the reference model
    for (int c = 0; c < 2000; c++) begin
      @(negedge clk_33m);
      check_model("rnd");
      rst = ($urandom_range(0, 199) == 0);
      for (int i = 0; i < N; i++)
        set_req(i, ($urandom_range(0, 9) < 6), ($urandom_range(0, 3) == 0),
                12'($urandom), 12'($urandom), 3'($urandom));
    end
    @(negedge clk_33m);
    check_model("rnd.end");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
